// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper phase sequencer.
//   coil_t      : 4-bit coil drive word, bit3..bit0 = A, B, A', B'
//   FULL_TABLE  : 4-entry full-step (two coils on) sequence
//   HALF_TABLE  : 8-entry half-step sequence
//   state_t     : sequencer FSM states
package stepper_pkg;

  typedef logic [3:0] coil_t;

  localparam int FULL_LEN = 4;
  localparam int HALF_LEN = 8;

  localparam coil_t FULL_TABLE [0:FULL_LEN-1] = '{
    4'b1100, 4'b0110, 4'b0011, 4'b1001
  };

  localparam coil_t HALF_TABLE [0:HALF_LEN-1] = '{
    4'b1000, 4'b1100, 4'b0100, 4'b0110,
    4'b0010, 4'b0011, 4'b0001, 4'b1001
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MOVE = 1'b1
  } state_t;

endpackage

// File: rtl/step_edge_sync.sv
// Two-flop synchroniser plus rising-edge detect for the asynchronous
// step-rate input.
//   clk           : system clock
//   reset_reset_n : asynchronous active-low reset, clears all flops
//   d_in          : asynchronous input (step_in)
//   rise_pulse    : one-clk pulse, high in the cycle after d_in's rising
//                   edge has passed both synchroniser flops
module step_edge_sync (
  input  logic clk,
  input  logic reset_reset_n,
  input  logic d_in,
  output logic rise_pulse
);

  logic sync_p0;
  logic sync_p1;
  logic sync_p2;

  always_ff @(posedge clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      // p0/p1: metastability stages; p2: previous synchronised value
      sync_p0 <= d_in;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign rise_pulse = sync_p1 & ~sync_p2;

endmodule

// File: rtl/stepper_phase_sequencer.sv
// Stepper motor phase sequencer: accepts move commands (direction, step
// count), advances the coil phase on each synchronised step_in rising edge,
// and tracks a signed position.
//   clk, reset_reset_n        : clock, asynchronous active-low reset
//   step_in                   : asynchronous step-rate square wave
//   enable                    : 1 = coils energised and ticks honoured
//   cmd_valid/cmd_ready       : move command handshake (ready only in IDLE)
//   cmd_dir, cmd_steps        : 1 = forward; step count (0 = no-op with done)
//   abort                     : ends the current move without done
//   coil                      : registered coil drive A, B, A', B'
//   busy, done                : in MOVE; one-clk completion pulse
//   position                  : signed step position, wraps in two's complement
// Build option: define STEPPER_HALF_STEP_EN for the 8-entry half-step table;
// otherwise the 4-entry full-step table is used.
module stepper_phase_sequencer
  import stepper_pkg::*;
#(
  parameter int POS_W   = 32,
  parameter int STEPS_W = 16
) (
  input  logic                    clk,
  input  logic                    reset_reset_n,
  input  logic                    step_in,
  input  logic                    enable,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_dir,
  input  logic [STEPS_W-1:0]      cmd_steps,
  input  logic                    abort,
  output logic [3:0]              coil,
  output logic                    busy,
  output logic                    done,
  output logic signed [POS_W-1:0] position
);

`ifdef STEPPER_HALF_STEP_EN
  localparam int TBL_LEN = HALF_LEN;
`else
  localparam int TBL_LEN = FULL_LEN;
`endif
  localparam int PH_W = $clog2(TBL_LEN);

  function automatic coil_t phase_coil(input logic [PH_W-1:0] idx);
`ifdef STEPPER_HALF_STEP_EN
    return HALF_TABLE[idx];
`else
    return FULL_TABLE[idx];
`endif
  endfunction

  state_t                    state;
  logic                      dir_q;
  logic [STEPS_W-1:0]        remaining;
  logic [PH_W-1:0]           phase;
  logic [PH_W-1:0]           phase_next;
  logic signed [POS_W-1:0]   pos_delta;
  logic                      tick;
  logic                      do_step;

  step_edge_sync u_sync (
    .clk           (clk),
    .reset_reset_n (reset_reset_n),
    .d_in          (step_in),
    .rise_pulse    (tick)
  );

  // Abort outranks a coincident tick; disabled ticks are dropped entirely.
  // Table lengths are powers of two, so the index wraps by plain overflow.
  always_comb begin
    do_step    = (state == ST_MOVE) && !abort && tick && enable;
    phase_next = phase;
    pos_delta  = dir_q ? POS_W'(1) : '1;
    if (do_step) begin
      phase_next = dir_q ? phase + PH_W'(1) : phase - PH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state     <= ST_IDLE;
      dir_q     <= 1'b0;
      remaining <= '0;
      phase     <= '0;
      position  <= '0;
      coil      <= 4'b0000;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (cmd_steps == '0) begin
              done <= 1'b1;
            end else begin
              dir_q     <= cmd_dir;
              remaining <= cmd_steps;
              state     <= ST_MOVE;
            end
          end
        end
        ST_MOVE: begin
          if (abort) begin
            remaining <= '0;
            state     <= ST_IDLE;
          end else if (do_step) begin
            position  <= position + pos_delta;
            remaining <= remaining - STEPS_W'(1);
            if (remaining == STEPS_W'(1)) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
      phase <= phase_next;
      coil  <= enable ? phase_coil(phase_next) : 4'b0000;
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state == ST_MOVE);

endmodule

// File: tb/tb_stepper_phase_sequencer.sv
// Bench for stepper_phase_sequencer, built with a narrow position counter so
// two's-complement wrap is reachable with a short move.
module tb_stepper_phase_sequencer;

  localparam int POS_W   = 8;
  localparam int STEPS_W = 16;

`ifdef STEPPER_HALF_STEP_EN
  localparam int LEN = 8;
  localparam logic [3:0] TBL [0:7] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                       4'b0010, 4'b0011, 4'b0001, 4'b1001};
  localparam logic [3:0] EXP_FWD [0:4] = '{4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011};
  localparam logic [3:0] EXP_REV [0:2] = '{4'b1001, 4'b0001, 4'b0011};
  localparam logic [3:0] EXP_EN  [0:3] = '{4'b1100, 4'b0100, 4'b0110, 4'b0010};
  localparam logic [3:0] IDLE0   = 4'b1000;
  localparam logic [3:0] WRAP130 = 4'b0100;
`else
  localparam int LEN = 4;
  localparam logic [3:0] TBL [0:3] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
  localparam logic [3:0] EXP_FWD [0:4] = '{4'b0110, 4'b0011, 4'b1001, 4'b1100, 4'b0110};
  localparam logic [3:0] EXP_REV [0:2] = '{4'b1001, 4'b0011, 4'b0110};
  localparam logic [3:0] EXP_EN  [0:3] = '{4'b0110, 4'b0011, 4'b1001, 4'b1100};
  localparam logic [3:0] IDLE0   = 4'b1100;
  localparam logic [3:0] WRAP130 = 4'b0011;
`endif

  logic                    clk = 1'b0;
  logic                    reset_reset_n = 1'b0;
  logic                    step_in = 1'b0;
  logic                    enable = 1'b1;
  logic                    cmd_valid = 1'b0;
  logic                    cmd_ready;
  logic                    cmd_dir = 1'b0;
  logic [STEPS_W-1:0]      cmd_steps = '0;
  logic                    abort = 1'b0;
  logic [3:0]              coil;
  logic                    busy;
  logic                    done;
  logic signed [POS_W-1:0] position;

  int vectors = 0;
  int miscompares = 0;
  int done_seen = 0;

  stepper_phase_sequencer #(.POS_W(POS_W), .STEPS_W(STEPS_W)) dut (
    .clk           (clk),
    .reset_reset_n (reset_reset_n),
    .step_in       (step_in),
    .enable        (enable),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_dir       (cmd_dir),
    .cmd_steps     (cmd_steps),
    .abort         (abort),
    .coil          (coil),
    .busy          (busy),
    .done          (done),
    .position      (position)
  );

  always #5 clk = ~clk;

  // Reference model: integer position, phase kept modulo table length,
  // step_in history sampled at each clock to locate the two-cycle tick delay.
  int         m_pos = 0;
  int         m_phase = 0;
  int         m_rem = 0;
  bit         m_busy = 0;
  bit         m_dir = 0;
  bit         m_done = 0;
  logic [3:0] m_coil = 4'b0000;
  bit         h1 = 0, h2 = 0, h3 = 0;

  function automatic int wrap_pos(input int p);
    int span;
    int r;
    span = 1 << POS_W;
    r = p % span;
    if (r < 0) r += span;
    if (r >= span / 2) r -= span;
    return r;
  endfunction

  initial forever begin
    bit tick;
    @(posedge clk or negedge reset_reset_n);
    if (!reset_reset_n) begin
      m_pos = 0; m_phase = 0; m_rem = 0; m_busy = 0; m_done = 0;
      m_coil = 4'b0000; h1 = 0; h2 = 0; h3 = 0;
    end else begin
      // rising edge sampled two clocks earlier acts at this edge
      tick = h2 && !h3;
      h3 = h2; h2 = h1; h1 = step_in;
      m_done = 0;
      if (!m_busy) begin
        if (cmd_valid) begin
          if (int'(cmd_steps) == 0) m_done = 1;
          else begin
            m_busy = 1; m_dir = cmd_dir; m_rem = int'(cmd_steps);
          end
        end
      end else if (abort) begin
        m_busy = 0;
      end else if (tick && enable) begin
        m_phase = (m_phase + (m_dir ? 1 : LEN - 1)) % LEN;
        m_pos   = m_pos + (m_dir ? 1 : -1);
        m_rem   = m_rem - 1;
        if (m_rem == 0) begin
          m_busy = 0; m_done = 1;
        end
      end
      m_coil = enable ? TBL[m_phase] : 4'b0000;
    end
  end

  always @(negedge clk) begin
    vectors++;
    if (coil !== m_coil || int'(position) != wrap_pos(m_pos) || busy !== m_busy ||
        cmd_ready !== !m_busy || done !== m_done) begin
      miscompares++;
      $display("FAIL cycle t=%0t: coil %b/%b pos %0d/%0d busy %b/%b ready %b/%b done %b/%b (actual/required)",
               $time, coil, m_coil, position, wrap_pos(m_pos), busy, m_busy,
               cmd_ready, !m_busy, done, m_done);
    end
    if (done === 1'b1) done_seen++;
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #2 reset_reset_n = 1'b0;
    @(negedge clk); #2 reset_reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_cmd(input bit dir, input int steps);
    cmd_valid = 1'b1; cmd_dir = dir; cmd_steps = STEPS_W'(steps);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic step_pulse();
    step_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step_release();
    step_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    // reset state
    #7;
    check("rst_coil", int'(coil), 0);
    check("rst_pos", int'(position), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_done", int'(done), 0);
    @(negedge clk); #2 reset_reset_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("idle_coil", int'(coil), int'(IDLE0));

    // forward 5
    d0 = done_seen;
    send_cmd(1'b1, 5);
    check("fwd_busy", int'(busy), 1);
    for (int i = 0; i < 5; i++) begin
      step_pulse();
      check($sformatf("fwd_coil%0d", i), int'(coil), int'(EXP_FWD[i]));
      step_release();
    end
    check("fwd_pos", int'(position), 5);
    check("fwd_done", done_seen - d0, 1);
    check("fwd_ready", int'(cmd_ready), 1);

    // reverse 3 from phase 0
    do_reset();
    send_cmd(1'b0, 3);
    for (int i = 0; i < 3; i++) begin
      step_pulse();
      check($sformatf("rev_coil%0d", i), int'(coil), int'(EXP_REV[i]));
      step_release();
    end
    check("rev_pos", int'(position), -3);

    // zero-step command
    d0 = done_seen;
    send_cmd(1'b1, 0);
    check("zero_done", int'(done), 1);
    check("zero_busy", int'(busy), 0);
    @(negedge clk);
    check("zero_done_clr", int'(done), 0);
    check("zero_pos", int'(position), -3);

    // abort in IDLE has no effect
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    check("idle_abort_ready", int'(cmd_ready), 1);

    // tick in the acceptance cycle is ignored
    do_reset();
    step_in = 1'b1;
    @(negedge clk); @(negedge clk);
    send_cmd(1'b1, 3);
    check("acc_tick_busy", int'(busy), 1);
    check("acc_tick_pos", int'(position), 0);
    check("acc_tick_coil", int'(coil), int'(IDLE0));
    step_release();
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    check("acc_abort_busy", int'(busy), 0);

    // abort coincident with the 3rd tick of 10
    do_reset();
    d0 = done_seen;
    send_cmd(1'b1, 10);
    for (int i = 0; i < 2; i++) begin
      step_pulse(); step_release();
    end
    step_in = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_pos", int'(position), 2);
    step_release();
    check("abort_no_done", done_seen - d0, 0);

    // enable dropped mid-move
    do_reset();
    d0 = done_seen;
    send_cmd(1'b1, 4);
    step_pulse();
    check("en_coil0", int'(coil), int'(EXP_EN[0]));
    step_release();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step_pulse(); step_release();
    end
    check("en_off_coil", int'(coil), 0);
    check("en_off_pos", int'(position), 1);
    check("en_off_busy", int'(busy), 1);
    enable = 1'b1;
    @(negedge clk);
    check("en_on_coil", int'(coil), int'(EXP_EN[0]));
    for (int i = 1; i < 4; i++) begin
      step_pulse();
      check($sformatf("en_coil%0d", i), int'(coil), int'(EXP_EN[i]));
      check($sformatf("en_pos%0d", i), int'(position), i + 1);
      step_release();
    end
    check("en_done", done_seen - d0, 1);

    // long forward move through positive wrap
    do_reset();
    send_cmd(1'b1, 130);
    for (int i = 0; i < 130; i++) begin
      step_pulse();
      if (i == 126) check("wrap_max", int'(position), 127);
      if (i == 127) check("wrap_neg", int'(position), -128);
      step_release();
    end
    check("wrap_final_pos", int'(position), -126);
    check("wrap_final_coil", int'(coil), int'(WRAP130));
    check("wrap_idle", int'(busy), 0);

    // asynchronous reset mid-move
    do_reset();
    send_cmd(1'b1, 10);
    for (int i = 0; i < 2; i++) begin
      step_pulse(); step_release();
    end
    @(posedge clk); #2 reset_reset_n = 1'b0;
    #1;
    check("amid_coil", int'(coil), 0);
    check("amid_pos", int'(position), 0);
    check("amid_busy", int'(busy), 0);
    check("amid_done", int'(done), 0);
    check("amid_ready", int'(cmd_ready), 1);
    @(negedge clk); #2 reset_reset_n = 1'b1;
    @(negedge clk);
    check("amid_release_coil", int'(coil), int'(IDLE0));
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stepper_phase_sequencer.md
STEPPER_PHASE_SEQUENCER -- requirements
Module: stepper_phase_sequencer

Interface
REQ-001 The block SHALL have parameter POS_W, default 32, meaning the signed position counter width.
REQ-002 The block SHALL have parameter STEPS_W, default 16, meaning the unsigned command step-count width.
REQ-003 clk  in  1  the single system clock; all state updates on its rising edge.
REQ-004 reset_reset_n  in  1  reset, asynchronous and active-low.
REQ-005 step_in  in  1  step-rate square wave from the clock divider, asynchronous to clk; each rising edge is one step tick.
REQ-006 enable  in  1  1 = coils energised and ticks honoured; 0 = coils off and ticks ignored.
REQ-007 cmd_valid  in  1  move command offered.
REQ-008 cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are 1.
REQ-009 cmd_dir  in  1  1 = forward (+1 per step), 0 = reverse.
REQ-010 cmd_steps  in  STEPS_W  number of steps to execute.
REQ-011 abort  in  1  terminate the current move.
REQ-012 coil  out  4  registered coil drive A, B, A', B' (bit3..bit0).
REQ-013 busy  out  1  1 while in MOVE.
REQ-014 done  out  1  one-clk pulse on move completion.
REQ-015 position  out  POS_W  signed step position.

Function
REQ-016 step_in SHALL pass through a 2-flop synchroniser followed by a rising-edge detect producing a one-clk tick; if step_in is sampled high at edge N after being low, the coil/position update SHALL be visible after edge N+2.
REQ-017 The FSM SHALL have states IDLE and MOVE; cmd_ready = 1 exactly in IDLE; busy = 1 exactly in MOVE.
REQ-018 On acceptance with cmd_steps > 0, the block SHALL latch cmd_dir and cmd_steps into remaining and enter MOVE on the next edge.
REQ-019 On acceptance with cmd_steps = 0, the block SHALL stay in IDLE and pulse done in the next cycle, with no motion.
REQ-020 Ticks in IDLE, including a tick in the acceptance cycle, SHALL be ignored.
REQ-021 In MOVE, each tick with enable = 1 SHALL advance the phase index by +1 (forward) or -1 (reverse) modulo the table length, add ±1 to position, and decrement remaining.
REQ-022 The tick that brings remaining to 0 SHALL return the FSM to IDLE and pulse done for exactly one cycle at the same edge.
REQ-023 abort in MOVE SHALL return the FSM to IDLE at the next edge without a done pulse; if abort and a tick coincide, abort wins and no step occurs; abort in IDLE SHALL have no effect.
REQ-024 position SHALL wrap in two's complement, e.g. max positive + 1 -> most negative.
REQ-025 Phase index wrap-around SHALL be seamless in both directions (last -> 0 forward, 0 -> last reverse).
REQ-026 coil SHALL be table[phase index] when enable = 1 and 4'b0000 when enable = 0; the phase index SHALL be retained while enable = 0.
REQ-027 Ticks with enable = 0 SHALL be ignored in MOVE: no step, no decrement, and the FSM SHALL stay in MOVE.

Reset
REQ-028 Asserting reset SHALL immediately, including mid-move, force: state IDLE, coil 0000, position 0, phase index 0, remaining 0, done 0, and clear the synchroniser and edge-detect flops.
REQ-029 Outputs after release SHALL be: cmd_ready 1, busy 0, coil = table[0] if enable = 1.

Configuration
REQ-030 With macro STEPPER_HALF_STEP_EN defined, the table SHALL have 8 entries: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
REQ-031 Without STEPPER_HALF_STEP_EN, the table SHALL have 4 full-step entries: 1100, 0110, 0011, 1001; the phase index width SHALL follow the table length.

Structure
REQ-032 A shared package stepper_pkg SHALL hold both phase tables, the table-length constants, and the FSM state typedef.
REQ-033 The synchroniser plus edge detect SHALL be the sub-module step_edge_sync (ports clk, reset_reset_n, d_in, rise_pulse).

Verification
REQ-034 Full-step build: accept forward cmd_steps = 5 from reset, send 5 step_in edges -> coil 0110, 0011, 1001, 1100, 0110; position 5; one done pulse; cmd_ready 1.
REQ-035 Reverse cmd_steps = 3 from phase 0 -> coil 1001, 0011, 0110; position -3.
REQ-036 cmd_steps = 0 -> done pulses one cycle later; busy never 1; position unchanged.
REQ-037 Abort after 2 of 10 steps, coincident with the 3rd tick -> position 2, no done, IDLE next cycle.
REQ-038 enable = 0 mid-move with 3 ticks -> coil 0000, position frozen; after enable = 1, remaining steps complete correctly.
REQ-039 Half-step build with position preset near 2^(POS_W-1)-1 (via a long forward move) -> 8-entry sequence observed; position wraps to negative; reset mid-move clears all outputs asynchronously.
